// File: rtl/dmem_responder.sv
// Data-memory responder: 8-byte little-endian load/store with bounds check for the Y86-64 memory stage.
// Latency: a request accepted at edge k is answered by a one-cycle rsp_valid after edge k+LATENCY.
// Backpressure: req_ready drops while a request is outstanding; req_valid without req_ready is ignored.
module dmem_responder #(
   parameter int DEPTH_BYTES = 2048,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int          AW       = $clog2(DEPTH_BYTES);
   localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            lat_write;
   logic [63:0]     lat_addr;
   logic [63:0]     lat_wdata;
   logic [7:0]      mem [DEPTH_BYTES];
   logic            addr_err;
   logic [AW-1:0]   base;
   logic [63:0]     rd_word;
   logic            commit;

   // The full 64-bit compare catches both high address bits and accesses straddling the top.
   assign addr_err = (lat_addr > MAX_ADDR);
   assign base     = lat_addr[AW-1:0];
   // The access completes on the edge that leaves WAIT; a reset on that edge cancels it.
   assign commit   = rst_n && (state == WAIT) && (cnt == '0);

   // Gather the 8 bytes at the latched address, lowest address in the least significant byte.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 8; i++) begin
         rd_word[8*i +: 8] = mem[base + AW'(i)];
      end
   end

   // Storage is never reset; a good store lands on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (commit && lat_write && !addr_err) begin
         for (int i = 0; i < 8; i++) begin
            mem[base + AW'(i)] <= lat_wdata[8*i +: 8];
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   // Every request passes through WAIT so the response timing is LATENCY edges for any LATENCY >= 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  cnt       <= CW'(LATENCY - 1);
                  state     <= WAIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= addr_err;
                  rsp_rdata <= (addr_err || lat_write) ? 64'd0 : rd_word;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance on a shared clock.
// Accepted requests are recorded in a per-instance queue; responses are checked against a byte model.
// Inputs change 2 time units after the rising edge; everything is sampled on the falling edge.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_err;
   logic [1:0]  busy;
   logic [63:0] req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [63:0] rsp_rdata [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;

   // Rising-edge counter used to time responses.
   always @(posedge clk) cyc++;

   dmem_responder #(.DEPTH_BYTES(2048), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
   );

   dmem_responder #(.DEPTH_BYTES(2048), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          due;
   } rec_t;

   // Per-instance scoreboard and reference byte model.
   for (genvar g = 0; g < 2; g++) begin : mon
      localparam int LAT = (g == 0) ? 2 : 1;
      rec_t        q[$];
      int          acc[$];
      logic [7:0]  model [2048];
      rec_t        r;
      logic        e_err;
      logic [63:0] e_dat;

      // Compare each response with the oldest accepted request, then log new acceptances.
      always @(negedge clk) begin
         if (mon_en) begin
            if (!rst_n[g]) begin
               check_eq("rsp_in_reset", 64'(rsp_valid[g]), 64'd0);
               q.delete();
            end else begin
               check_eq("req_ready", 64'(req_ready[g]), 64'(q.size() == 0));
               check_eq("busy", 64'(busy[g]), 64'(q.size() != 0));
               if (rsp_valid[g]) begin
                  if (q.size() == 0) begin
                     check_eq("spurious_rsp", 64'(rsp_valid[g]), 64'd0);
                  end else begin
                     r     = q.pop_front();
                     e_err = (r.addr > 64'd2040);
                     e_dat = '0;
                     if (!e_err && !r.wr) begin
                        for (int i = 0; i < 8; i++) e_dat[8*i +: 8] = model[r.addr[10:0] + 11'(i)];
                     end
                     check_eq("rsp_cycle", 64'(cyc), 64'(r.due));
                     check_eq("rsp_err", 64'(rsp_err[g]), 64'(e_err));
                     check_eq("rsp_rdata", rsp_rdata[g], e_dat);
                     if (!e_err && r.wr) begin
                        for (int i = 0; i < 8; i++) model[r.addr[10:0] + 11'(i)] = r.wdata[8*i +: 8];
                     end
                  end
               end else if (q.size() != 0 && cyc >= q[0].due) begin
                  check_eq("rsp_missing", 64'(rsp_valid[g]), 64'd1);
                  void'(q.pop_front());
               end
               if (req_valid[g] && req_ready[g]) begin
                  q.push_back('{req_write[g], req_addr[g], req_wdata[g], cyc + 1 + LAT});
                  acc.push_back(cyc);
               end
            end
         end
      end
   end

   task automatic drive_req(input int d, input logic wr, input logic [63:0] a, input logic [63:0] w);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = a;
      req_wdata[d] = w;
   endtask

   // Present one request, hold it until accepted, then scramble the bus.
   task automatic send(input int d, input logic wr, input logic [63:0] a, input logic [63:0] w);
      int n;
      n = 0;
      @(posedge clk); #2;
      drive_req(d, wr, a, w);
      do begin @(negedge clk); n++; end while (!req_ready[d] && n < 50);
      if (!req_ready[d]) check_eq("accept_timeout", 64'(req_ready[d]), 64'd1);
      @(posedge clk); #2;
      req_valid[d] = 1'b0;
      req_addr[d]  = ~a;
      req_wdata[d] = ~w;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!req_ready[d] && n < 50);
      if (!req_ready[d]) check_eq("idle_timeout", 64'(req_ready[d]), 64'd1);
   endtask

   task automatic xfer(input int d, input logic wr, input logic [63:0] a, input logic [63:0] w);
      send(d, wr, a, w);
      wait_idle(d);
   endtask

   // req_valid held high with alternating store/load; RESP must drain to IDLE before the
   // next acceptance, so accepts are LATENCY+2 = 4 edges apart.
   task automatic burst();
      int n;
      mon[0].acc.delete();
      @(posedge clk); #2;
      drive_req(0, 1'b1, 64'h100, {32'hC0DE0000, $urandom()});
      for (int i = 0; i < 6; i++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
         if (!req_ready[0]) check_eq("burst_timeout", 64'(req_ready[0]), 64'd1);
         @(posedge clk); #2;
         if (i < 5)
            drive_req(0, ((i + 1) % 2) == 0, 64'h100 + 64'(8 * ((i + 1) - ((i + 1) % 2))),
                      {32'hC0DE0000 | 32'(i + 1), $urandom()});
         else
            req_valid[0] = 1'b0;
      end
      wait_idle(0);
      check_eq("burst_accepts", 64'(mon[0].acc.size()), 64'd6);
      for (int k = 1; k < mon[0].acc.size(); k++)
         check_eq("accept_interval", 64'(mon[0].acc[k] - mon[0].acc[k-1]), 64'd4);
   endtask

   initial begin
      rst_n     = 2'b00;
      req_valid = 2'b00;
      req_write = 2'b00;
      for (int d = 0; d < 2; d++) begin
         req_addr[d]  = '0;
         req_wdata[d] = '0;
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 2'b11;

      // Idle after reset.
      repeat (4) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", 64'(req_ready[d]), 64'd1);
            check_eq("rst_busy", 64'(busy[d]), 64'd0);
            check_eq("rst_rsp_valid", 64'(rsp_valid[d]), 64'd0);
            check_eq("rst_rdata", rsp_rdata[d], 64'd0);
            check_eq("rst_err", 64'(rsp_err[d]), 64'd0);
         end
      end
      mon_en = 1'b1;

      // Store then loads, including an unaligned one.
      xfer(0, 1'b1, 64'h10, 64'h0123456789ABCDEF);
      xfer(0, 1'b1, 64'h18, 64'h1122334455667788);
      xfer(0, 1'b0, 64'h10, 64'h0);
      xfer(0, 1'b0, 64'h11, 64'h0);
      check_eq("unaligned_low_byte", 64'(rsp_rdata[0][7:0]), 64'hCD);

      // Bounds.
      xfer(0, 1'b1, 64'h7F8, 64'hFEEDFACECAFEBEEF);
      xfer(0, 1'b0, 64'h7F8, 64'h0);
      xfer(0, 1'b0, 64'h7F9, 64'h0);
      xfer(0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h0BADBADBADBADBAD);
      xfer(0, 1'b0, 64'h7F8, 64'h0);
      xfer(0, 1'b0, 64'h8000000000000010, 64'h0);

      // Back-to-back handshake.
      burst();

      // Reset during WAIT aborts the store.
      xfer(0, 1'b1, 64'h20, 64'h5555555555555555);
      send(0, 1'b1, 64'h20, 64'hAAAAAAAAAAAAAAAA);
      rst_n[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n[0] = 1'b1;
      @(negedge clk);
      check_eq("midrst_rdata", rsp_rdata[0], 64'd0);
      check_eq("midrst_ready", 64'(req_ready[0]), 64'd1);
      xfer(0, 1'b0, 64'h20, 64'h0);

      // LATENCY=1 instance.
      xfer(1, 1'b1, 64'h40, 64'h8877665544332211);
      xfer(1, 1'b0, 64'h40, 64'h0);
      xfer(1, 1'b0, 64'h43, 64'h0);
      xfer(1, 1'b0, 64'h7F9, 64'h0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
